// File: rtl/mfe_led7seg_scan_scheduler_pkg.sv
// Shared definitions for the 7-segment scan scheduler and its 595 shift controller:
// the FSM state encoding, the default geometry, and an address-width helper.
package mfe_led7seg_scan_scheduler_pkg;

  localparam int DEF_DIG_NUM = 8;
  localparam int DEF_SEG_NUM = 8;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_WAIT  = 3'd1,
    ST_ISSUE = 3'd2,
    ST_HOLD  = 3'd3,
    ST_DRAIN = 3'd4
  } scan_state_t;

  // The floor of 1 keeps a single-digit build from producing zero-width ports.
  function automatic int addr_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/mfe_led7seg_frame_buf.sv
// Per-digit segment frame buffer: synchronous write, combinational read, synchronous clear.
module mfe_led7seg_frame_buf
  import mfe_led7seg_scan_scheduler_pkg::*;
#(
  parameter int DIG_NUM = DEF_DIG_NUM,
  parameter int SEG_NUM = DEF_SEG_NUM,
  parameter int AW      = addr_w(DIG_NUM)
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               wr_en,
  input  logic [AW-1:0]      wr_addr,
  input  logic [SEG_NUM-1:0] wr_data,
  input  logic [AW-1:0]      rd_addr,
  output logic [SEG_NUM-1:0] rd_data
);

  logic [DIG_NUM-1:0][SEG_NUM-1:0] mem;

  always_ff @(posedge clk) begin
    if (rst)
      mem <= '0;
    else if (wr_en && (32'(wr_addr) < DIG_NUM))
      mem[wr_addr] <= wr_data;
  end

  // Addresses beyond DIG_NUM only exist for non-power-of-two digit counts.
  assign rd_data = (32'(rd_addr) < DIG_NUM) ? mem[rd_addr] : '0;

endmodule

// File: rtl/mfe_led7seg_scan_scheduler.sv
// Time-multiplexed 7-segment scan scheduler: walks the frame buffer one digit per slot
// and hands {digit enables, segments} words to a 595 shift controller.
module mfe_led7seg_scan_scheduler
  import mfe_led7seg_scan_scheduler_pkg::*;
#(
  parameter int DIG_NUM     = DEF_DIG_NUM,
  parameter int SEG_NUM     = DEF_SEG_NUM,
  parameter int REFRESH_DIV = 1024,
  parameter bit DIG_ACT_LOW = 1'b1,
  parameter bit SEG_ACT_LOW = 1'b1
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        enable,
  input  logic                        wr_en,
  input  logic [addr_w(DIG_NUM)-1:0]  wr_addr,
  input  logic [SEG_NUM-1:0]          wr_data,
  output logic [DIG_NUM+SEG_NUM-1:0]  dat,
  output logic                        vld,
  input  logic                        rdy,
  output logic                        frame_done
);

  localparam int AW = addr_w(DIG_NUM);
  localparam logic [DIG_NUM-1:0] DIG_INV  = {DIG_NUM{DIG_ACT_LOW}};
  localparam logic [SEG_NUM-1:0] SEG_INV  = {SEG_NUM{SEG_ACT_LOW}};
  localparam logic [AW-1:0]      IDX_LAST = AW'(DIG_NUM - 1);
  localparam logic [15:0]        CNT_LAST = 16'(REFRESH_DIV - 1);

  scan_state_t          state;
  logic [AW-1:0]        idx;
  logic [15:0]          cnt;
  logic [SEG_NUM-1:0]   seg;
  logic [DIG_NUM-1:0]   dig_oh;
  logic [DIG_NUM+SEG_NUM-1:0] word;

  mfe_led7seg_frame_buf #(
    .DIG_NUM (DIG_NUM),
    .SEG_NUM (SEG_NUM),
    .AW      (AW)
  ) u_frame_buf (
    .clk     (clk),
    .rst     (rst),
    .wr_en   (wr_en),
    .wr_addr (wr_addr),
    .wr_data (wr_data),
    .rd_addr (idx),
    .rd_data (seg)
  );

  // Digit 0 sits in the MSB of the enable field.
  always_comb begin
    dig_oh = '0;
    for (int i = 0; i < DIG_NUM; i++)
      dig_oh[i] = (idx == AW'(DIG_NUM - 1 - i));
    word = {dig_oh ^ DIG_INV, seg ^ SEG_INV};
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= ST_IDLE;
      idx        <= '0;
      cnt        <= '0;
      vld        <= 1'b0;
      frame_done <= 1'b0;
      dat        <= {DIG_INV, SEG_INV};
    end else begin
      vld        <= 1'b0;
      frame_done <= 1'b0;
      case (state)
        ST_IDLE: begin
          idx <= '0;
          cnt <= '0;
          if (enable) state <= ST_WAIT;
        end
        ST_WAIT: begin
          if (!enable) begin
            state <= ST_IDLE;
            idx   <= '0;
            cnt   <= '0;
          end else if (cnt == CNT_LAST) begin
            state <= ST_ISSUE;
            cnt   <= '0;
          end else begin
            cnt <= cnt + 16'd1;
          end
        end
        ST_ISSUE: begin
          // A write landing this same edge is not visible in word, so the old entry goes out.
          if (!enable) begin
            state <= ST_IDLE;
            idx   <= '0;
          end else if (rdy) begin
            dat   <= word;
            vld   <= 1'b1;
            state <= ST_HOLD;
          end
        end
        ST_HOLD: state <= ST_DRAIN;
        ST_DRAIN: begin
          if (rdy) begin
            if (idx == IDX_LAST) begin
              idx        <= '0;
              frame_done <= 1'b1;
            end else begin
              idx <= enable ? idx + AW'(1) : '0;
            end
            state <= enable ? ST_WAIT : ST_IDLE;
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mfe_led7seg_scan_scheduler.sv
// Scoreboard bench for the scan scheduler: expected words are queued by the stimulus
// and popped by a monitor on every vld pulse.
module tb_mfe_led7seg_scan_scheduler;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        enable = 1'b0;
  logic        wr_en = 1'b0;
  logic [2:0]  wr_addr = '0;
  logic [7:0]  wr_data = '0;
  logic [15:0] dat;
  logic        vld;
  logic        rdy;
  logic        frame_done;

  logic        busy = 1'b0;
  logic        force_low = 1'b0;
  logic [15:0] exp_q[$];
  int          checks = 0;
  int          errors = 0;
  int          fd_count = 0;

  assign rdy = !busy && !force_low;

  always #5 clk = ~clk;

  mfe_led7seg_scan_scheduler #(
    .DIG_NUM     (8),
    .SEG_NUM     (8),
    .REFRESH_DIV (4),
    .DIG_ACT_LOW (1'b1),
    .SEG_ACT_LOW (1'b1)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .enable     (enable),
    .wr_en      (wr_en),
    .wr_addr    (wr_addr),
    .wr_data    (wr_data),
    .dat        (dat),
    .vld        (vld),
    .rdy        (rdy),
    .frame_done (frame_done)
  );

  // Shift-controller model: rdy drops the cycle after vld and returns 34 cycles later.
  initial forever begin
    @(negedge clk);
    if (vld) begin
      @(posedge clk); #1 busy = 1'b1;
      repeat (34) @(posedge clk);
      #1 busy = 1'b0;
    end
  end

  // Monitor
  initial forever begin
    logic [15:0] e;
    @(negedge clk);
    if (frame_done) fd_count++;
    if (vld) begin
      checks++;
      if (exp_q.size() == 0) begin
        errors++;
        $display("FAIL unexpected_vld: got dat=%h with nothing expected", dat);
      end else begin
        e = exp_q.pop_front();
        if (dat !== e) begin
          errors++;
          $display("FAIL xfer_dat: got %h expected %h", dat, e);
        end
      end
    end
  end

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] want);
    checks++;
    if (got !== want) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, got, want);
    end
  endtask

  task automatic wait_drain(input string name, input int budget);
    int n = 0;
    while (exp_q.size() != 0 && n < budget) begin
      @(posedge clk); #2;
      n++;
    end
    if (exp_q.size() != 0) begin
      checks++;
      errors++;
      $display("FAIL %s_timeout: %0d transfers outstanding, expected 0", name, exp_q.size());
      exp_q.delete();
    end
  endtask

  task automatic wait_fd(input int target, input int budget);
    int n = 0;
    while (fd_count < target && n < budget) begin
      @(posedge clk); #2;
      n++;
    end
    check("frame_done_count", fd_count, target);
  endtask

  task automatic write_buf(input logic [2:0] a, input logic [7:0] d);
    @(posedge clk); #1;
    wr_en = 1'b1; wr_addr = a; wr_data = d;
    @(posedge clk); #1;
    wr_en = 1'b0;
  endtask

  initial begin
    logic [15:0] frame1[8];
    int lat;
    int vcnt;
    frame1 = '{16'h7FFF, 16'hBFFF, 16'hDFFF, 16'hEFC0, 16'hF7FF, 16'hFBFF, 16'hFDFF, 16'hFEFF};

    // Reset state
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_vld", vld, 0);
    check("rst_dat", dat, 16'hFFFF);
    check("rst_frame_done", frame_done, 0);
    @(posedge clk); #1 rst = 1'b0;

    // First frame, buffer[3]=3F, plus first-transfer latency
    write_buf(3'd3, 8'h3F);
    foreach (frame1[i]) exp_q.push_back(frame1[i]);
    @(posedge clk); #1 enable = 1'b1;
    lat = 0;
    while (lat < 20) begin
      @(posedge clk); @(negedge clk);
      lat++;
      if (vld) break;
    end
    checks++;
    if (lat < 5 || lat > 6) begin
      errors++;
      $display("FAIL first_latency: got %0d cycles expected 5..6", lat);
    end
    wait_drain("frame1", 1000);
    wait_fd(1, 100);

    // Hold rdy low in ISSUE, then release with a same-cycle write to digit 0
    force_low = 1'b1;
    vcnt = 0;
    repeat (20) begin
      @(negedge clk);
      if (vld) vcnt++;
    end
    check("rdy_low_no_vld", vcnt, 0);
    exp_q.push_back(16'h7FFF);
    @(posedge clk); #1;
    force_low = 1'b0;
    wr_en = 1'b1; wr_addr = 3'd0; wr_data = 8'hFF;
    @(posedge clk); #1 wr_en = 1'b0;
    @(negedge clk);
    check("vld_first_rdy_cycle", vld, 1);
    for (int i = 1; i < 8; i++) exp_q.push_back(frame1[i]);
    exp_q.push_back(16'h7F00);
    wait_drain("frame2", 1000);
    check("frame_done_after_frame2", fd_count, 2);

    // Drop enable in HOLD of digit 1
    exp_q.push_back(16'hBFFF);
    lat = 0;
    while (lat < 200) begin
      @(negedge clk);
      lat++;
      if (vld) break;
    end
    enable = 1'b0;
    check("hold_vld_seen", vld, 1);
    repeat (80) @(posedge clk);
    #2 check("no_vld_after_disable", exp_q.size(), 0);
    check("no_frame_done_on_disable", fd_count, 2);
    exp_q.push_back(16'h7F00);
    @(posedge clk); #1 enable = 1'b1;
    wait_drain("restart", 300);

    // Reset during DRAIN of digit 0
    repeat (3) @(posedge clk);
    #1 rst = 1'b1;
    @(posedge clk);
    @(negedge clk);
    check("rst_drain_vld", vld, 0);
    check("rst_drain_dat", dat, 16'hFFFF);
    @(posedge clk); #1 rst = 1'b0;
    exp_q.push_back(16'h7FFF);
    exp_q.push_back(16'hBFFF);
    exp_q.push_back(16'hDFFF);
    exp_q.push_back(16'hEFFF);
    wait_drain("after_rst", 600);

    enable = 1'b0;
    repeat (60) @(posedge clk);
    #2 check("queue_empty_end", exp_q.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
